// File: rtl/serial_tx16.sv
// serial_tx16: framed LSB-first serial transmitter for 16-bit words
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   load  : transmit request, accepted only in IDLE
//   in    : word captured when load is accepted
//   out   : serial line, idles high (start 0, 16 data bits LSB-first, stop 1)
//   busy  : high during START, DATA and STOP
//   done  : one-cycle pulse after the stop bit
module serial_tx16 #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] in,
    output logic        out,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_BIT - 1);

    state_t        state, state_d;
    logic [TW-1:0] tick, tick_d;
    logic [3:0]    bit_cnt, bit_cnt_d;
    logic [15:0]   shift, shift_d;
    logic          out_d, busy_d, done_d;
    logic          tick_end;

    assign tick_end = tick == TICK_MAX;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            out     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            tick    <= tick_d;
            bit_cnt <= bit_cnt_d;
            shift   <= shift_d;
            out     <= out_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    state_d = load ? START : IDLE;
            START:   state_d = tick_end ? DATA : START;
            DATA:    state_d = (tick_end && bit_cnt == 4'd15) ? STOP : DATA;
            STOP:    state_d = tick_end ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; the bit counter wraps 15->0 on the same edge
    // that leaves DATA, so it is already 0 for the next frame.
    always_comb begin
        tick_d    = (state == IDLE || tick_end) ? '0 : tick + 1'b1;
        bit_cnt_d = state != DATA ? 4'd0 : tick_end ? bit_cnt + 4'd1 : bit_cnt;
        shift_d   = (state == IDLE && load) ? in :
                    (state == DATA && tick_end) ? shift >> 1 : shift;
    end

    // Outputs are derived from next-state values so the registered line
    // changes on the same edge as the state it represents.
    always_comb begin
        out_d  = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
        busy_d = state_d != IDLE;
        done_d = state == STOP && tick_end;
    end
endmodule

// File: tb/tb_serial_tx16.sv
// tb_serial_tx16: randomized self-checking bench for serial_tx16
module tb_serial_tx16;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0, load1 = 1'b0;
    logic [15:0] in = '0, in1 = '0;
    logic        out, busy, done, out1, busy1, done1;
    int          checks = 0, failures = 0;
    logic        cap_out [0:255];
    logic        cap_busy[0:255];
    logic        cap_done[0:255];

    serial_tx16 #(.CLKS_PER_BIT(4)) dut (
        .clk(clk), .reset(reset), .load(load), .in(in),
        .out(out), .busy(busy), .done(done)
    );

    serial_tx16 #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset(reset), .load(load1), .in(in1),
        .out(out1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    // Expected line level i cycles after the accepting edge.
    function automatic logic exp_line(input logic [15:0] w, input int cpb, input int i);
        int b;
        b = i / cpb;
        if (i >= 18 * cpb) return 1'b1;
        if (b == 0) return 1'b0;
        if (b <= 16) return w[b-1];
        return 1'b1;
    endfunction

    task automatic arm(input bit sel, input logic [15:0] w);
        @(negedge clk);
        if (sel) begin load1 = 1'b1; in1 = w; end
        else begin load = 1'b1; in = w; end
    endtask

    // Records n cycles of outputs; scrambles `in` every cycle and raises load at poke_at.
    task automatic capture(input bit sel, input int n, input int poke_at, input logic [15:0] poke_w);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_out[i]  = sel ? out1 : out;
            cap_busy[i] = sel ? busy1 : busy;
            cap_done[i] = sel ? done1 : done;
            if (sel) begin
                load1 = i == poke_at;
                in1   = i == poke_at ? poke_w : 16'($urandom);
            end else begin
                load = i == poke_at;
                in   = i == poke_at ? poke_w : 16'($urandom);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({out, busy, done, out1, busy1, done1} !== 6'b100100) begin
            failures++;
            $display("FAIL reset_init: got %b%b%b %b%b%b want 100 100", out, busy, done, out1, busy1, done1);
        end
        reset = 1'b0;
        arm(0, 16'($urandom));
        capture(0, 2, -1, 16'h0);
        checks++;
        if (cap_out[1] !== 1'b0 || cap_busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre: got out=%b busy=%b want 0 1", cap_out[1], cap_busy[1]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out, busy, done} !== 3'b100) begin
            failures++;
            $display("FAIL reset_async: got %b%b%b want 100", out, busy, done);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({out, busy, done} !== 3'b100) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got %b%b%b want 100", c, out, busy, done);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single_frame;
        arm(0, 16'hA5C3);
        capture(0, 75, -1, 16'h0);
        for (int i = 0; i < 75; i++) begin
            checks++;
            if (cap_out[i] !== exp_line(16'hA5C3, 4, i) || cap_busy[i] !== (i < 72) || cap_done[i] !== (i == 72)) begin
                failures++;
                $display("FAIL single[%0d]: got out=%b busy=%b done=%b want %b %b %b", i,
                         cap_out[i], cap_busy[i], cap_done[i], exp_line(16'hA5C3, 4, i), i < 72, i == 72);
            end
        end
    endtask

    task automatic test_load_while_busy;
        int pulses;
        arm(0, 16'h00FF);
        capture(0, 75, 19, 16'hFFFF);
        pulses = 0;
        for (int i = 0; i < 75; i++) begin
            pulses += int'(cap_done[i]);
            checks++;
            if (cap_out[i] !== exp_line(16'h00FF, 4, i) || cap_busy[i] !== (i < 72)) begin
                failures++;
                $display("FAIL busy_load[%0d]: got out=%b busy=%b want %b %b", i,
                         cap_out[i], cap_busy[i], exp_line(16'h00FF, 4, i), i < 72);
            end
        end
        checks++;
        if (pulses != 1 || cap_done[72] !== 1'b1) begin
            failures++;
            $display("FAIL busy_load_done: got %0d pulses (done@72=%b) want 1", pulses, cap_done[72]);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] w1, got;
        int j;
        w1 = 16'($urandom);
        arm(0, w1);
        capture(0, 147, 72, 16'h8001);
        for (int i = 0; i < 147; i++) begin
            logic eo, eb, ed;
            j  = i - 73;
            eo = i <= 72 ? exp_line(w1, 4, i) : exp_line(16'h8001, 4, j);
            eb = i <= 72 ? i < 72 : j < 72;
            ed = i == 72 || j == 72;
            checks++;
            if (cap_out[i] !== eo || cap_busy[i] !== eb || cap_done[i] !== ed) begin
                failures++;
                $display("FAIL b2b[%0d]: got out=%b busy=%b done=%b want %b %b %b", i,
                         cap_out[i], cap_busy[i], cap_done[i], eo, eb, ed);
            end
        end
        for (int k = 0; k < 16; k++) got[k] = cap_out[73 + (k + 1) * 4 + 2];
        checks++;
        if (got !== 16'h8001 || cap_out[73] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_word: got %h start=%b want 8001 start=0", got, cap_out[73]);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] w;
        w = 16'($urandom) & ~16'h0080;
        arm(0, w);
        capture(0, 34, -1, 16'h0);
        checks++;
        if (cap_out[33] !== 1'b0 || cap_busy[33] !== 1'b1) begin
            failures++;
            $display("FAIL mid_bit7: got out=%b busy=%b want 0 1", cap_out[33], cap_busy[33]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out, busy, done} !== 3'b100) begin
            failures++;
            $display("FAIL mid_reset: got %b%b%b want 100", out, busy, done);
        end
        @(negedge clk);
        checks++;
        if ({out, busy, done} !== 3'b100) begin
            failures++;
            $display("FAIL mid_reset_hold: got %b%b%b want 100", out, busy, done);
        end
        reset = 1'b0;
        load = 1'b1;
        in = 16'h1234;
        capture(0, 75, -1, 16'h0);
        for (int i = 0; i < 75; i++) begin
            checks++;
            if (cap_out[i] !== exp_line(16'h1234, 4, i) || cap_busy[i] !== (i < 72) || cap_done[i] !== (i == 72)) begin
                failures++;
                $display("FAIL after_reset[%0d]: got out=%b busy=%b done=%b want %b %b %b", i,
                         cap_out[i], cap_busy[i], cap_done[i], exp_line(16'h1234, 4, i), i < 72, i == 72);
            end
        end
    endtask

    task automatic test_cpb1(input logic [15:0] w);
        arm(1, w);
        capture(1, 21, -1, 16'h0);
        for (int i = 0; i < 21; i++) begin
            checks++;
            if (cap_out[i] !== exp_line(w, 1, i) || cap_busy[i] !== (i < 18) || cap_done[i] !== (i == 18)) begin
                failures++;
                $display("FAIL cpb1_%h[%0d]: got out=%b busy=%b done=%b want %b %b %b", w, i,
                         cap_out[i], cap_busy[i], cap_done[i], exp_line(w, 1, i), i < 18, i == 18);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] w;
        for (int r = 0; r < 6; r++) begin
            w = 16'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            arm(0, w);
            capture(0, 74, 30 + r, 16'($urandom));
            for (int i = 0; i < 74; i++) begin
                checks++;
                if (cap_out[i] !== exp_line(w, 4, i) || cap_busy[i] !== (i < 72) || cap_done[i] !== (i == 72)) begin
                    failures++;
                    $display("FAIL rand%0d_%h[%0d]: got out=%b busy=%b done=%b want %b %b %b", r, w, i,
                             cap_out[i], cap_busy[i], cap_done[i], exp_line(w, 4, i), i < 72, i == 72);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_load_while_busy;
        test_back_to_back;
        test_reset_mid_frame;
        test_cpb1(16'h0000);
        test_cpb1(16'($urandom));
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
